mac_tile_accumulator: RTL and testbench
=======================================

# mac_tile_accumulator

Parametrised ROWS×COLS fixed-point outer-product MAC tile, the successor to the fixed 2×16 MAC/round array. Each accepted beat supplies one activation vector (COLS values) and one weight vector (ROWS values). PE(r,c) accumulates a[c]·w[r] over a programmable number of beats, then rounds or truncates and saturates back to DATA_W. The result drains as ROWS output rows under valid/ready backpressure. It sits between the operand buffers and the result writeback path of the matrix engine.

## Interface
- ROWS, 2, weight lanes / output rows
- COLS, 16, activation lanes / output columns
- DATA_W, 16, signed operand and result width
- FRAC_BITS, 8, fractional bits of operands and results (1 ≤ FRAC_BITS < DATA_W)
- ACC_W, 40, signed accumulator width (≥ 2·DATA_W)
- KW, 8, width of k_len
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  KW  beats to accumulate; latched on start
- round_en  in  1  1 = round-half-up, 0 = truncate (floor); latched on start
- in_valid  in  1  operand beat valid
- in_ready  out  1  tile accepts operand beat
- in_act  in  COLS·DATA_W  activation vector, lane c at [c·DATA_W +: DATA_W]
- in_wgt  in  ROWS·DATA_W  weight vector, lane r at [r·DATA_W +: DATA_W]
- out_valid  out  1  out_row valid
- out_ready  in  1  downstream accepts row
- out_row  out  COLS·DATA_W  result row, column c at [c·DATA_W +: DATA_W]
- out_row_idx  out  $clog2(ROWS) (min 1)  index of the row presented
- out_last  out  1  presented row is ROWS-1
- busy  out  1  state ≠ IDLE
- sat_flag  out  1  sticky: some element of the current tile saturated; cleared on start

## Operation
- States: IDLE, ACCUM, ROUND, DRAIN.
- IDLE: in_ready=0, out_valid=0.
  - start=1 clears all accumulators, sat_flag, and the beat counter, and latches k_len and round_en.
  - Next state is ACCUM, or ROUND if k_len=0.
- ACCUM: in_ready=1. On each in_valid&in_ready, every acc[r][c] += sext(a[c]·w[r]).
  - The product is signed 2·DATA_W wide with 2·FRAC_BITS fractional bits. The accumulator wraps modulo 2^ACC_W.
  - The beat counter increments per handshake. On the handshake that makes count = k_len, next state is ROUND.
- ROUND, one cycle, for every element:
  - If round_en, v = (acc + 2^(FRAC_BITS−1)) >>> FRAC_BITS. Otherwise v = acc >>> FRAC_BITS (arithmetic shift).
  - Clamp v to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. Any clamp sets sat_flag.
  - Results are registered into the ROWS×COLS result buffer, and the row pointer is set to 0. Next state is DRAIN.
- DRAIN: out_valid=1 and out_row = buffer[ptr].
  - On out_ready, ptr increments. The handshake with out_last=1 returns the block to IDLE.
- start is ignored in ACCUM, ROUND, and DRAIN.
- in_valid is ignored outside ACCUM.

## Timing
- Reset values: state IDLE; in_ready=0; out_valid=0; out_row=0; out_row_idx=0; out_last=0; busy=0; sat_flag=0; accumulators and buffer=0.
- Asserting rst_n low at any time, including mid-ACCUM or mid-DRAIN, aborts immediately to the reset values. No partial rows are emitted afterward.
- start accepted at edge T: busy=1 and in_ready=1 from T+1.
- Last beat accepted at edge T: in_ready=0 from T+1 (ROUND). out_valid=1 with row 0 from T+2.
- k_len=0: start at T gives ROUND at T+1 and out_valid at T+2 with all-zero rows.
- Back-to-back beats are accepted every cycle; there are no bubbles in ACCUM.
- With out_valid=1 and out_ready=0, out_row, out_row_idx, and out_last hold stable.
- With out_ready held high, DRAIN lasts exactly ROWS cycles.
- After the final row handshake at edge T, busy=0 from T+1. A start at T+1 is accepted.
- sat_flag is valid from the first DRAIN cycle and holds until the next accepted start.
- Rounding example: −0.5 LSB rounds to 0 with round_en=1, and to −1 with round_en=0.

## Test plan
- Basic product (defaults), k_len=1, all a=0x0180 (1.5), all w=0x0200 (2.0) -> 2 rows of all 0x0300; out_valid 2 cycles after the beat; sat_flag=0.
- Accumulate and rounding, k_len=4, a[c]=0x0001, w[r]=0x0080 each beat.
  - round_en=1 -> every element 0x0002.
  - round_en=0 -> 0x0002.
  - k_len=1: round_en=1 gives 0x0001, round_en=0 gives 0x0000.
- Negative and saturation.
  - a=0xFFFF, w=0x0080, k_len=1: round_en=1 gives 0x0000; round_en=0 gives 0xFFFF.
  - a=w=0x7FFF, k_len=4: all 0x7FFF and sat_flag=1.
  - a=0x8000, w=0x7FFF: all 0x8000 and sat_flag=1.
- Backpressure: out_ready=0 for 3 cycles while row 1 is presented (ROWS=4) -> row 1 data and idx held; rows 0..3 each delivered exactly once; out_last only on row 3; start during DRAIN ignored.
- k_len=0 and in_valid gaps: k_len=0 -> zero rows at T+2; k_len=3 with in_valid toggling 1,0,1,0,1 -> sum of exactly 3 beats.
- Reset mid-operation: rst_n low after 2 of 5 beats, then a fresh tile -> outputs at reset values immediately; the fresh tile's result is uncontaminated by the aborted partial sums.

Source files
------------

// File: rtl/mac_tile_accumulator.sv
// mac_tile_accumulator: ROWS x COLS fixed-point outer-product MAC tile.
// Each accepted beat adds a[c]*w[r] into acc[r][c]. After k_len beats the
// accumulators are rounded or truncated, saturated to DATA_W and drained one
// row per out_valid/out_ready handshake.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, k_len, round_en  tile start (IDLE only), beat count, rounding mode
//   in_valid/in_ready       operand beat handshake; in_act (COLS lanes), in_wgt (ROWS lanes)
//   out_valid/out_ready     result row handshake; out_row, out_row_idx, out_last
//   busy, sat_flag          state != IDLE; sticky saturation for the current tile
module mac_tile_accumulator #(
  parameter int unsigned ROWS      = 2,
  parameter int unsigned COLS      = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned FRAC_BITS = 8,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned KW        = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [KW-1:0]                             k_len,
  input  logic                                      round_en,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [COLS*DATA_W-1:0]                    in_act,
  input  logic [ROWS*DATA_W-1:0]                    in_wgt,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [COLS*DATA_W-1:0]                    out_row,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_idx,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      sat_flag
);

  localparam int unsigned IDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] MIN_V = SUM_W'(-(64'sd1 <<< (DATA_W - 1)));
  localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(64'sd1 <<< (FRAC_BITS - 1));

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ROUND, S_DRAIN} state_e;

  state_e                    state_q;
  logic [KW-1:0]             cnt_q, klen_q;
  logic                      rnd_q;
  logic                      in_ready_q, out_valid_q, out_last_q, busy_q, sat_q;
  logic [IDX_W-1:0]          ptr_q;
  logic [COLS*DATA_W-1:0]    out_row_q;
  logic signed [ACC_W-1:0]   acc_q [ROWS][COLS];
  logic [DATA_W-1:0]         buf_q [ROWS][COLS];

  logic signed [PROD_W-1:0]  prod_d [ROWS][COLS];
  logic [DATA_W-1:0]         res_d  [ROWS][COLS];
  logic                      sat_d;
  logic signed [SUM_W-1:0]   rsum_d, rshift_d;
  logic [IDX_W-1:0]          ptr_inc_d;
  logic [KW-1:0]             cnt_inc_d;

  assign ptr_inc_d = ptr_q + IDX_W'(1);
  assign cnt_inc_d = cnt_q + KW'(1);

  // Signed lane products for the current beat.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        prod_d[r][c] = PROD_W'($signed(in_wgt[r*DATA_W +: DATA_W])) *
                       PROD_W'($signed(in_act[c*DATA_W +: DATA_W]));
      end
    end
  end

  // Round/truncate and saturate every accumulator; one extra bit keeps the
  // rounding offset from wrapping near the top of the accumulator range.
  always_comb begin
    sat_d    = 1'b0;
    rsum_d   = '0;
    rshift_d = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        rsum_d = SUM_W'(acc_q[r][c]);
        if (rnd_q) rsum_d = rsum_d + HALF;
        rshift_d = rsum_d >>> FRAC_BITS;
        if (rshift_d > MAX_V) begin
          res_d[r][c] = DATA_W'(MAX_V);
          sat_d       = 1'b1;
        end else if (rshift_d < MIN_V) begin
          res_d[r][c] = DATA_W'(MIN_V);
          sat_d       = 1'b1;
        end else begin
          res_d[r][c] = DATA_W'(rshift_d);
        end
      end
    end
  end

  // Tile control, accumulation, result buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      klen_q      <= '0;
      rnd_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      ptr_q       <= '0;
      out_row_q   <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          acc_q[r][c] <= '0;
          buf_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q  <= '0;
            klen_q <= k_len;
            rnd_q  <= round_en;
            sat_q  <= 1'b0;
            busy_q <= 1'b1;
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) acc_q[r][c] <= '0;
            end
            if (k_len == '0) begin
              state_q <= S_ROUND;
            end else begin
              state_q    <= S_ACCUM;
              in_ready_q <= 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            cnt_q <= cnt_inc_d;
            for (int r = 0; r < ROWS; r++) begin
              for (int c = 0; c < COLS; c++) begin
                acc_q[r][c] <= acc_q[r][c] + ACC_W'(prod_d[r][c]);
              end
            end
            if (cnt_inc_d == klen_q) begin
              state_q    <= S_ROUND;
              in_ready_q <= 1'b0;
            end
          end
        end
        S_ROUND: begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) buf_q[r][c] <= res_d[r][c];
          end
          for (int c = 0; c < COLS; c++) out_row_q[c*DATA_W +: DATA_W] <= res_d[0][c];
          sat_q       <= sat_q | sat_d;
          ptr_q       <= '0;
          out_valid_q <= 1'b1;
          out_last_q  <= (ROWS == 1);
          state_q     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= S_IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              ptr_q      <= ptr_inc_d;
              out_last_q <= (ptr_inc_d == IDX_W'(ROWS - 1));
              for (int c = 0; c < COLS; c++) begin
                out_row_q[c*DATA_W +: DATA_W] <= buf_q[ptr_inc_d][c];
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_row     = out_row_q;
  assign out_row_idx = ptr_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign sat_flag    = sat_q;

endmodule

// File: tb/tb_mac_tile_accumulator.sv
// Testbench for mac_tile_accumulator (ROWS=4, COLS=4): directed tiles, an
// arithmetic result model feeding an expected-row queue, and a negedge
// monitor comparing every presented row against that queue.
module tb_mac_tile_accumulator;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned FRAC   = 8;
  localparam int unsigned ACC_W  = 40;
  localparam int unsigned KW     = 8;
  localparam int unsigned IDX_W  = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [KW-1:0]          k_len = '0;
  logic                   round_en = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [COLS*DATA_W-1:0] in_act = '0;
  logic [ROWS*DATA_W-1:0] in_wgt = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [COLS*DATA_W-1:0] out_row;
  logic [IDX_W-1:0]       out_row_idx;
  logic                   out_last;
  logic                   busy;
  logic                   sat_flag;

  mac_tile_accumulator #(
    .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .FRAC_BITS(FRAC), .ACC_W(ACC_W), .KW(KW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .round_en(round_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] row;
    int          idx;
    bit          last;
  } exp_t;

  exp_t        exp_q[$];
  bit          exp_sat = 1'b0;
  logic [15:0] row0_seen = 16'hDEAD;
  int          n_checks = 0;
  int          n_fail = 0;
  string       cur = "reset";

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %h, expected %h", cur, name, act, exp);
    end
  endtask

  // Every presented row must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_row", 64'd1, 64'd0);
      end else begin
        check("row_data", out_row, exp_q[0].row);
        check("row_idx", 64'(out_row_idx), 64'(exp_q[0].idx));
        check("row_last", 64'(out_last), 64'(exp_q[0].last));
        check("sat_flag", 64'(sat_flag), 64'(exp_sat));
        if (out_ready) begin
          if (exp_q[0].idx == 0) row0_seen = out_row[15:0];
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive_beat(input shortint a[COLS], input shortint w[ROWS]);
    for (int c = 0; c < COLS; c++) in_act[c*DATA_W +: DATA_W] = a[c];
    for (int r = 0; r < ROWS; r++) in_wgt[r*DATA_W +: DATA_W] = w[r];
  endtask

  // Runs one tile from a posedge+1 time point: a[c]=a0+c*da, w[r]=w0+r*dw
  // every beat. lit00/lit_sat are hand-computed values for row 0 col 0.
  task automatic run_tile(input string nm, input int k, input bit rnd,
                          input int a0, input int da, input int w0, input int dw,
                          input bit gaps, input int stall_row,
                          input logic [15:0] lit00, input bit lit_sat);
    shortint     a[COLS];
    shortint     w[ROWS];
    longint      acc, v;
    logic [63:0] row;
    bit          sat, hs, hs_last, done;
    int          acc_n, cyc, stall_n;
    cur = nm;
    for (int c = 0; c < COLS; c++) a[c] = shortint'(a0 + c * da);
    for (int r = 0; r < ROWS; r++) w[r] = shortint'(w0 + r * dw);
    sat = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      row = '0;
      for (int c = 0; c < COLS; c++) begin
        acc = longint'(k) * longint'(a[c]) * longint'(w[r]);
        acc = (acc <<< (64 - ACC_W)) >>> (64 - ACC_W);
        v = rnd ? ((acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC) : (acc >>> FRAC);
        if (v > 32767) begin v = 32767; sat = 1'b1; end
        else if (v < -32768) begin v = -32768; sat = 1'b1; end
        row[c*DATA_W +: DATA_W] = 16'(v);
      end
      exp_q.push_back('{row: row, idx: r, last: (r == ROWS - 1)});
    end
    exp_sat   = sat;
    row0_seen = 16'hDEAD;

    // Start with a garbage beat presented; IDLE must ignore it.
    start = 1'b1; k_len = KW'(k); round_en = rnd; in_valid = 1'b1;
    in_act = {COLS{16'h5A5A}}; in_wgt = {ROWS{16'h5A5A}};
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("in_ready_after_start", 64'(in_ready), 64'(k != 0));

    acc_n = 0; cyc = 0;
    while (acc_n < k && cyc < 64) begin
      if (gaps && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
        in_act = {COLS{16'h7FFF}}; in_wgt = {ROWS{16'h7FFF}};
      end else begin
        in_valid = 1'b1;
        drive_beat(a, w);
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) acc_n++;
      cyc++;
    end
    in_valid = 1'b0;
    if (acc_n < k) check("beat_timeout", 64'(acc_n), 64'(k));
    check("in_ready_round", 64'(in_ready), 64'd0);
    check("out_valid_round", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("out_valid_t2", 64'(out_valid), 64'd1);
    check("idx_t2", 64'(out_row_idx), 64'd0);

    stall_n = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 64) begin
      if (out_valid && int'(out_row_idx) == stall_row && stall_n < 3) begin
        out_ready = 1'b0; start = 1'b1; stall_n++;
      end else begin
        out_ready = 1'b1; start = 1'b0;
      end
      hs_last = out_valid && out_ready && out_last;
      @(posedge clk); #1;
      cyc++;
      if (hs_last) begin
        check("busy_after_last", 64'(busy), 64'd0);
        done = 1'b1;
      end
    end
    out_ready = 1'b0; start = 1'b0;
    if (!done) check("drain_timeout", 64'd0, 64'd1);
    check("drain_cycles", 64'(cyc), 64'(ROWS + stall_n));
    check("rows_left", 64'(exp_q.size()), 64'd0);
    check("lit_row0_col0", 64'(row0_seen), 64'(lit00));
    check("lit_sat", 64'(sat_flag), 64'(lit_sat));
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_row", out_row, 64'd0);
    check("rst_idx", 64'(out_row_idx), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
  endtask

  initial begin
    shortint pa[COLS];
    shortint pw[ROWS];
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_tile("basic",      1, 1'b1, 16'h0180, 0, 16'h0200, 0, 1'b0, -1, 16'h0300, 1'b0);
    run_tile("acc4_rnd",   4, 1'b1, 16'h0001, 0, 16'h0080, 0, 1'b0, -1, 16'h0002, 1'b0);
    run_tile("acc4_trunc", 4, 1'b0, 16'h0001, 0, 16'h0080, 0, 1'b0, -1, 16'h0002, 1'b0);
    run_tile("k1_rnd",     1, 1'b1, 16'h0001, 0, 16'h0080, 0, 1'b0, -1, 16'h0001, 1'b0);
    run_tile("k1_trunc",   1, 1'b0, 16'h0001, 0, 16'h0080, 0, 1'b0, -1, 16'h0000, 1'b0);
    run_tile("neg_rnd",    1, 1'b1, -1,       0, 16'h0080, 0, 1'b0, -1, 16'h0000, 1'b0);
    run_tile("neg_trunc",  1, 1'b0, -1,       0, 16'h0080, 0, 1'b0, -1, 16'hFFFF, 1'b0);
    run_tile("sat_pos",    4, 1'b1, 16'h7FFF, 0, 16'h7FFF, 0, 1'b0, -1, 16'h7FFF, 1'b1);
    run_tile("sat_neg",    1, 1'b0, -32768,   0, 16'h7FFF, 0, 1'b0, -1, 16'h8000, 1'b1);
    run_tile("backpress",  2, 1'b0, 16'h0100, 16'h0040, 16'h0100, 16'h0080, 1'b0, 1, 16'h0200, 1'b0);
    run_tile("k0",         0, 1'b1, 16'h0100, 0, 16'h0100, 0, 1'b0, -1, 16'h0000, 1'b0);
    run_tile("gaps",       3, 1'b0, 16'h0100, 0, 16'h0100, 0, 1'b1, -1, 16'h0300, 1'b0);

    // Abort after 2 of 5 large beats, then a fresh small tile.
    cur = "reset_mid";
    for (int c = 0; c < COLS; c++) pa[c] = 16'h4000;
    for (int r = 0; r < ROWS; r++) pw[r] = 16'h4000;
    start = 1'b1; k_len = KW'(5); round_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    drive_beat(pa, pw);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_tile("after_reset", 1, 1'b0, 16'h0100, 0, 16'h0100, 0, 1'b0, -1, 16'h0100, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
